innings_controller: RTL and testbench

Match sequencer directly upstream of `score_and_wickets`. It converts the bowl button into single-cycle `play` strobes and counts legal deliveries into balls and overs. It ends each innings on overs, wickets or a successful chase, and drives `teamSwitch` and `gameOver`. It reads `team1Data`/`team2Data` back from the scoring block to decide innings end and the winner.

---
 rtl/innings_controller.sv | 127 ++++++++++++
 tb/tb_innings_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/innings_controller.sv
// Match sequencer: turns the bowl button into single-cycle play strobes, counts legal
// deliveries into balls/overs and ends innings on overs, wickets or a successful chase.
module innings_controller #(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int MAX_WICKETS    = 10
) (
  input  logic        clk_fpga,
  input  logic        reset_n,
  input  logic        bowl_btn,
  input  logic [3:0]  lfsr_out,
  input  logic [11:0] team1Data,
  input  logic [11:0] team2Data,
  output logic        play,
  output logic        teamSwitch,
  output logic        gameOver,
  output logic [2:0]  ball_in_over,
  output logic [4:0]  over_count,
  output logic [1:0]  winner
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INN1  = 3'd1;
  localparam logic [2:0] EVAL1 = 3'd2;
  localparam logic [2:0] BREAK = 3'd3;
  localparam logic [2:0] INN2  = 3'd4;
  localparam logic [2:0] EVAL2 = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0] state;
  logic       sync1, sync2, btn_prev;
  logic       press;
  logic [3:0] code_q;

  logic       legal;
  logic [3:0] ball_inc;
  logic [2:0] ball_next;
  logic [4:0] over_next;
  logic [3:0] bat_wickets;
  logic       chase;
  logic       inn_end;
  logic [1:0] result;

  assign press = sync2 & ~btn_prev;
  assign play  = press & ((state == INN1) | (state == INN2));

  // Post-delivery counters and end-of-innings test, used only in the EVAL states.
  always_comb begin
    legal     = (code_q != 4'd13) && (code_q != 4'd14);
    ball_inc  = {1'b0, ball_in_over} + 4'd1;
    ball_next = ball_in_over;
    over_next = over_count;
    if (legal) begin
      if (ball_inc == 4'(BALLS_PER_OVER)) begin
        ball_next = '0;
        over_next = over_count + 5'd1;
      end else begin
        ball_next = ball_inc[2:0];
      end
    end
    bat_wickets = (state == EVAL2) ? team2Data[3:0] : team1Data[3:0];
    chase       = (state == EVAL2) && (team2Data[11:4] > team1Data[11:4]);
    inn_end     = (bat_wickets >= 4'(MAX_WICKETS)) || (over_next == 5'(MAX_OVERS)) || chase;
    if (team2Data[11:4] > team1Data[11:4]) begin
      result = 2'b10;
    end else if (team2Data[11:4] < team1Data[11:4]) begin
      result = 2'b01;
    end else begin
      result = 2'b11;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (!reset_n) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      btn_prev     <= 1'b0;
      code_q       <= 4'd0;
      teamSwitch   <= 1'b0;
      gameOver     <= 1'b0;
      ball_in_over <= 3'd0;
      over_count   <= 5'd0;
      winner       <= 2'b00;
    end else begin
      sync1    <= bowl_btn;
      sync2    <= sync1;
      btn_prev <= sync2;
      case (state)
        IDLE: if (press) state <= INN1;
        INN1, INN2: begin
          if (press) begin
            code_q <= lfsr_out;
            state  <= (state == INN1) ? EVAL1 : EVAL2;
          end
        end
        EVAL1: begin
          if (inn_end) begin
            state        <= BREAK;
            teamSwitch   <= 1'b1;
            ball_in_over <= 3'd0;
            over_count   <= 5'd0;
          end else begin
            state        <= INN1;
            ball_in_over <= ball_next;
            over_count   <= over_next;
          end
        end
        BREAK: if (press) state <= INN2;
        EVAL2: begin
          ball_in_over <= ball_next;
          over_count   <= over_next;
          if (inn_end) begin
            state    <= DONE;
            gameOver <= 1'b1;
            winner   <= result;
          end else begin
            state <= INN2;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_innings_controller.sv
// Randomised and scripted match bench for innings_controller: a scoreboard of expected
// per-delivery outcomes from a reference model, checked by an independent monitor.
module tb_innings_controller;

  localparam int BPO = 6;
  localparam int MO  = 20;
  localparam int MW  = 10;

  logic        clk_fpga = 1'b0;
  logic        reset_n  = 1'b0;
  logic        bowl_btn = 1'b0;
  logic [3:0]  lfsr_out = 4'd0;
  logic [11:0] team1Data, team2Data;
  logic        play, teamSwitch, gameOver;
  logic [2:0]  ball_in_over;
  logic [4:0]  over_count;
  logic [1:0]  winner;

  innings_controller #(
    .BALLS_PER_OVER(BPO),
    .MAX_OVERS     (MO),
    .MAX_WICKETS   (MW)
  ) dut (
    .clk_fpga    (clk_fpga),
    .reset_n     (reset_n),
    .bowl_btn    (bowl_btn),
    .lfsr_out    (lfsr_out),
    .team1Data   (team1Data),
    .team2Data   (team2Data),
    .play        (play),
    .teamSwitch  (teamSwitch),
    .gameOver    (gameOver),
    .ball_in_over(ball_in_over),
    .over_count  (over_count),
    .winner      (winner)
  );

  always #5 clk_fpga = ~clk_fpga;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bench-owned scoring rule: 0..11 -> code%4 runs, 12 -> 6, wides 1, wicket 0.
  function automatic logic [7:0] runs_of(input logic [3:0] code);
    if (code == 4'd15) return 8'd0;
    if (code == 4'd13 || code == 4'd14) return 8'd1;
    if (code == 4'd12) return 8'd6;
    return {6'd0, code[1:0]};
  endfunction

  // Stand-in for the downstream scoring block.
  logic [7:0] sb_runs [2];
  logic [3:0] sb_wk [2];
  assign team1Data = {sb_runs[0], sb_wk[0]};
  assign team2Data = {sb_runs[1], sb_wk[1]};

  always @(posedge clk_fpga) begin
    if (!reset_n) begin
      sb_runs[0] <= 8'd0; sb_runs[1] <= 8'd0;
      sb_wk[0]   <= 4'd0; sb_wk[1]   <= 4'd0;
    end else if (play && !gameOver) begin
      sb_runs[teamSwitch] <= sb_runs[teamSwitch] + runs_of(lfsr_out);
      if (lfsr_out == 4'd15) sb_wk[teamSwitch] <= sb_wk[teamSwitch] + 4'd1;
    end
  end

  // Reference model: match phase plus per-innings totals.
  typedef enum int {PhIdle, PhInn1, PhBreak, PhInn2, PhDone} phase_t;
  phase_t     phase;
  int         legal_balls;
  logic [7:0] m_runs [2];
  int         m_wk [2];

  typedef struct {
    logic       ts_play;
    int         ball;
    int         over;
    logic       ts;
    logic       go;
    logic [1:0] win;
  } exp_t;
  exp_t sb_q[$];

  task automatic model_clear();
    phase = PhIdle;
    legal_balls = 0;
    m_runs[0] = 8'd0; m_runs[1] = 8'd0;
    m_wk[0] = 0; m_wk[1] = 0;
  endtask

  task automatic press(input logic [3:0] code);
    exp_t e;
    int   bat;
    bit   ended;
    if (phase == PhInn1 || phase == PhInn2) begin
      bat = (phase == PhInn2) ? 1 : 0;
      e.ts_play = logic'(bat);
      m_runs[bat] += runs_of(code);
      if (code == 4'd15) m_wk[bat]++;
      if (code != 4'd13 && code != 4'd14) legal_balls++;
      ended = (m_wk[bat] >= MW) || (legal_balls == MO * BPO) ||
              (phase == PhInn2 && m_runs[1] > m_runs[0]);
      if (ended && phase == PhInn1) begin
        phase = PhBreak;
        legal_balls = 0;
      end else if (ended) begin
        phase = PhDone;
      end
      e.ball = legal_balls % BPO;
      e.over = legal_balls / BPO;
      e.ts   = (phase != PhInn1);
      e.go   = (phase == PhDone);
      if (phase != PhDone) e.win = 2'b00;
      else if (m_runs[1] > m_runs[0]) e.win = 2'b10;
      else if (m_runs[1] < m_runs[0]) e.win = 2'b01;
      else e.win = 2'b11;
      sb_q.push_back(e);
    end else if (phase == PhIdle) begin
      phase = PhInn1;
    end else if (phase == PhBreak) begin
      phase = PhInn2;
    end
    @(negedge clk_fpga);
    lfsr_out = code;
    bowl_btn = 1'b1;
    repeat (3) @(negedge clk_fpga);
    bowl_btn = 1'b0;
    repeat (3) @(negedge clk_fpga);
  endtask

  task automatic do_reset();
    @(negedge clk_fpga);
    reset_n  = 1'b0;
    bowl_btn = 1'b0;
    @(negedge clk_fpga);
    check("rst_play", play, 0);
    check("rst_teamSwitch", teamSwitch, 0);
    check("rst_gameOver", gameOver, 0);
    check("rst_ball_in_over", ball_in_over, 0);
    check("rst_over_count", over_count, 0);
    check("rst_winner", winner, 0);
    check("pending_deliveries", sb_q.size(), 0);
    sb_q.delete();
    model_clear();
    reset_n = 1'b1;
    repeat (2) @(negedge clk_fpga);
  endtask

  // Monitor: every play strobe consumes one expected delivery.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_fpga);
      if (play === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_play: got play=1, expected no delivery (phase %0d)", phase);
        end else begin
          e = sb_q.pop_front();
          check("teamSwitch_at_play", teamSwitch, e.ts_play);
          @(negedge clk_fpga);
          check("play_one_cycle", play, 0);
          @(negedge clk_fpga);
          check("ball_in_over", ball_in_over, e.ball);
          check("over_count", over_count, e.over);
          check("teamSwitch", teamSwitch, e.ts);
          check("gameOver", gameOver, e.go);
          check("winner", winner, e.win);
        end
      end
    end
  end

  initial begin
    int n;
    model_clear();
    do_reset();

    // Scripted opening: counters, wides/no-balls, ten wickets, then a mid-innings-2 reset.
    press(4'd0);
    repeat (7) press(4'd3);
    press(4'd13);
    press(4'd14);
    press(4'd0);
    repeat (10) press(4'd15);
    press(4'd0);
    repeat (5) press(4'($urandom_range(0, 11)));
    do_reset();

    // Dot balls for both full innings: tie.
    press(4'd0);
    repeat (MO * BPO) press(4'd0);
    press(4'd0);
    repeat (MO * BPO) press(4'd0);
    repeat (2) press(4'd0);
    do_reset();

    // Chase: team 1 makes 20, team 2 passes it with a six on ball 4.
    press(4'd0);
    repeat (3) press(4'd12);
    press(4'd2);
    repeat (10) press(4'd15);
    press(4'd0);
    repeat (2) press(4'd12);
    press(4'd3);
    press(4'd12);
    repeat (2) press(4'd5);
    do_reset();

    // Fully random match.
    n = 0;
    while (phase != PhDone && n < 1000) begin
      press(4'($urandom_range(0, 15)));
      n++;
    end
    press(4'd1);

    repeat (10) @(negedge clk_fpga);
    check("queue_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
